// File: rtl/learn_player.sv
// Guided song playback: lights the expected key, sounds the note while it is held, scores hits/misses.
// Define LEARN_TIMEOUT_EN to add a GUIDE timeout (parameter TIMEOUT_BEATS) that counts a miss and skips the note.
module learn_player #(
    parameter int NUM_KEYS    = 7,
    parameter int NUM_SONGS   = 6,
    parameter int SONG_LEN    = 64,
    parameter int BEAT_CYCLES = 25000000,
    parameter int CNT_W       = 8,
`ifdef LEARN_TIMEOUT_EN
    parameter int TIMEOUT_BEATS = 8,
`endif
    localparam int SONG_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
    localparam int ADDR_W = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                song_next,
    input  logic                song_prev,
    input  logic [NUM_KEYS-1:0] switches,
    input  logic [1:0]          octave_sel,
    output logic [SONG_W-1:0]   rom_song,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [3:0]          rom_note,
    input  logic [1:0]          rom_octave,
    input  logic [3:0]          rom_dur,
    output logic [3:0]          note_out,
    output logic [1:0]          octave_out,
    output logic [NUM_KEYS-1:0] led_out,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt,
    output logic                pass_done,
    output logic [2:0]          dbg_state
);

    localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int DUR_W  = 4 + BEAT_W;
    localparam logic [3:0]        MAX_KEY   = 4'(NUM_KEYS);
    localparam logic [3:0]        END_CODE  = 4'hF;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
    localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
    localparam logic [DUR_W-1:0]  BEAT_LEN  = DUR_W'(BEAT_CYCLES);

    typedef enum logic [2:0] {S_FETCH, S_LOAD, S_GUIDE, S_HOLD, S_REST} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, addr_inc;
    logic [SONG_W-1:0]   song_q, song_d;
    logic [3:0]          note_q, note_d, dur_q, dur_d;
    logic [1:0]          oct_q, oct_d;
    logic [DUR_W-1:0]    cnt_q, cnt_d, dur_last;
    logic [CNT_W-1:0]    hit_q, hit_d, miss_q, miss_d;
    logic                wrong_q, next_q, prev_q;
    logic [NUM_KEYS-1:0] key_mask;
    logic                correct, wrong_now, rom_is_key, rom_is_end;
    logic                next_rise, prev_rise, song_chg, dur_done, miss_inc;

`ifdef LEARN_TIMEOUT_EN
    localparam longint TMO_CYCLES = longint'(TIMEOUT_BEATS) * longint'(BEAT_CYCLES);
    localparam int TMO_W = $clog2(TMO_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    assign rom_song  = song_q;
    assign rom_addr  = addr_q;
    assign hit_cnt   = hit_q;
    assign miss_cnt  = miss_q;
    assign dbg_state = state_q;

    always_comb begin
        key_mask = '0;
        if (note_q != 4'd0 && note_q <= MAX_KEY)
            key_mask = NUM_KEYS'(1) << (note_q - 4'd1);
    end

    // A zero duration plays as one beat; the counter runs 0 .. dur*BEAT_CYCLES-1.
    assign dur_last   = DUR_W'((dur_q == 4'd0) ? 4'd1 : dur_q) * BEAT_LEN - DUR_W'(1);
    assign dur_done   = (cnt_q == dur_last);
    assign correct    = (key_mask != '0) && (switches == key_mask) && (octave_sel == oct_q);
    assign wrong_now  = (state_q == S_GUIDE) && (|switches) && !correct;
    assign rom_is_key = (rom_note != 4'd0) && (rom_note <= MAX_KEY);
    assign rom_is_end = (rom_note == END_CODE) || ((addr_q == LAST_ADDR) && !rom_is_key);
    assign addr_inc   = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    assign next_rise  = song_next && !next_q;
    assign prev_rise  = song_prev && !prev_q;
    assign song_chg   = next_rise ^ prev_rise;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        song_d     = song_q;
        note_d     = note_q;
        oct_d      = oct_q;
        dur_d      = dur_q;
        cnt_d      = cnt_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        miss_inc   = wrong_now && !wrong_q;
        note_out   = 4'd0;
        octave_out = 2'b00;
        led_out    = '0;
        pass_done  = 1'b0;
`ifdef LEARN_TIMEOUT_EN
        tmo_d      = '0;
`endif
        case (state_q)
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                note_d = rom_note;
                oct_d  = rom_octave;
                dur_d  = rom_dur;
                cnt_d  = '0;
                if (rom_is_end) begin
                    pass_done = 1'b1;
                    addr_d    = '0;
                    state_d   = S_FETCH;
                end else if (rom_is_key) begin
                    state_d = S_GUIDE;
                end else begin
                    state_d = S_REST;
                end
            end
            S_GUIDE: begin
                led_out = key_mask;
                if (correct) begin
                    state_d = S_HOLD;
`ifdef LEARN_TIMEOUT_EN
                end else if (tmo_q == TMO_LAST) begin
                    miss_inc = 1'b1;
                    addr_d   = addr_inc;
                    state_d  = S_FETCH;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
`endif
                end
            end
            S_HOLD: begin
                led_out    = key_mask;
                octave_out = oct_q;
                // Releasing the key pauses the count; only held cycles contribute.
                if (correct) begin
                    note_out = note_q;
                    if (dur_done) begin
                        if (!(&hit_q)) hit_d = hit_q + CNT_W'(1);
                        cnt_d   = '0;
                        addr_d  = addr_inc;
                        state_d = S_FETCH;
                    end else begin
                        cnt_d = cnt_q + DUR_W'(1);
                    end
                end
            end
            S_REST: begin
                if (dur_done) begin
                    cnt_d   = '0;
                    addr_d  = addr_inc;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + DUR_W'(1);
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (miss_inc && !(&miss_q)) miss_d = miss_q + CNT_W'(1);

        // A song change overrides whatever the note logic decided this cycle.
        if (song_chg) begin
            if (next_rise) song_d = (song_q == LAST_SONG) ? '0 : song_q + SONG_W'(1);
            else           song_d = (song_q == '0) ? LAST_SONG : song_q - SONG_W'(1);
            addr_d     = '0;
            cnt_d      = '0;
            hit_d      = '0;
            miss_d     = '0;
            state_d    = S_FETCH;
            note_out   = 4'd0;
            octave_out = 2'b00;
            led_out    = '0;
            pass_done  = 1'b0;
`ifdef LEARN_TIMEOUT_EN
            tmo_d      = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            addr_q  <= '0;
            song_q  <= '0;
            note_q  <= 4'd0;
            oct_q   <= 2'b00;
            dur_q   <= 4'd0;
            cnt_q   <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            wrong_q <= 1'b0;
            next_q  <= song_next;
            prev_q  <= song_prev;
`ifdef LEARN_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            song_q  <= song_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
            dur_q   <= dur_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            wrong_q <= wrong_now;
            next_q  <= song_next;
            prev_q  <= song_prev;
`ifdef LEARN_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_learn_player.sv
// Bench for learn_player: directed scenarios, then random songs played against a note-list model.
module tb_learn_player;

    localparam int NK = 7;
    localparam int NS = 6;
    localparam int SL = 8;
    localparam int BC = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          song_next, song_prev;
    logic [NK-1:0] switches;
    logic [1:0]    octave_sel;
    logic [2:0]    rom_song;
    logic [2:0]    rom_addr;
    logic [3:0]    rom_note;
    logic [1:0]    rom_octave;
    logic [3:0]    rom_dur;
    logic [3:0]    note_out;
    logic [1:0]    octave_out;
    logic [NK-1:0] led_out;
    logic [CW-1:0] hit_cnt, miss_cnt;
    logic          pass_done;
    logic [2:0]    dbg_state;

    logic [9:0] rom_mem [NS][SL];
    int checks = 0;
    int errors = 0;
    int hit_exp, miss_exp;

    learn_player #(
        .NUM_KEYS(NK), .NUM_SONGS(NS), .SONG_LEN(SL), .BEAT_CYCLES(BC), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .song_next(song_next), .song_prev(song_prev),
        .switches(switches), .octave_sel(octave_sel), .rom_song(rom_song),
        .rom_addr(rom_addr), .rom_note(rom_note), .rom_octave(rom_octave),
        .rom_dur(rom_dur), .note_out(note_out), .octave_out(octave_out),
        .led_out(led_out), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
        .pass_done(pass_done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // External song ROM: registered, one-cycle read latency.
    always @(posedge clk) begin
        rom_note   <= rom_mem[rom_song][rom_addr][9:6];
        rom_octave <= rom_mem[rom_song][rom_addr][5:4];
        rom_dur    <= rom_mem[rom_song][rom_addr][3:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_led(input logic [NK-1:0] exp, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (led_out !== exp && n < 200);
        chk(tag, led_out, exp);
    endtask

    task automatic change_song(input logic [2:0] exp_song);
        song_next = 1'b1;
        step();
        chk("song_next_idx", rom_song, exp_song);
        chk("song_next_addr", rom_addr, 0);
        song_next = 1'b0;
        step();
    endtask

    task automatic play_key(input logic [3:0] note, input logic [1:0] oct, input logic [3:0] dur);
        logic [NK-1:0] one, mask, other;
        int total, sounded, rel_at, n;
        bit released;
        one   = NK'(1);
        mask  = one << (note - 4'd1);
        other = one << (note % 7);
        total = ((dur == 4'd0) ? 1 : int'(dur)) * BC;
        wait_led(mask, "rnd_led");
        if ($urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 2))
                0: switches = other;
                1: begin switches = mask; octave_sel = (oct == 2'd2) ? 2'd0 : oct + 2'd1; end
                default: switches = mask | other;
            endcase
            step();
            step();
            chk("rnd_wrong_silent", note_out, 0);
            switches = '0;
            step();
            miss_exp++;
        end
        switches   = mask;
        octave_sel = oct;
        sounded    = 0;
        released   = ($urandom_range(0, 1) == 0);
        rel_at     = $urandom_range(1, total - 1);
        n          = 0;
        while (n < 200) begin
            step();
            n++;
            if (!released && sounded == rel_at) begin
                released = 1'b1;
                switches = '0;
                #1;
                chk("rnd_release_silent", note_out, 0);
                step();
                n++;
                switches = mask;
            end
            #1;
            if (led_out === '0) break;
            if (note_out === note && octave_out === oct) sounded++;
        end
        chk("rnd_hold_cycles", sounded, total);
        switches = '0;
        hit_exp++;
    endtask

    task automatic play_song(input int s);
        logic [9:0] exp_q[$];
        logic [9:0] e;
        int n;
        hit_exp  = 0;
        miss_exp = 0;
        for (int a = 0; a < SL; a++) begin
            if (rom_mem[s][a][9:6] == 4'hF) break;
            if (rom_mem[s][a][9:6] >= 4'd1 && rom_mem[s][a][9:6] <= 4'd7) exp_q.push_back(rom_mem[s][a]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            play_key(e[9:6], e[5:4], e[3:0]);
        end
        n = 0;
        while (pass_done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("rnd_pass_done", pass_done, 1);
        chk("rnd_hit_cnt", hit_cnt, hit_exp);
        chk("rnd_miss_cnt", miss_cnt, miss_exp);
    endtask

    initial begin
        int sounded, n, len, r;
        logic [3:0] nt;
        for (int s = 0; s < NS; s++)
            for (int a = 0; a < SL; a++)
                rom_mem[s][a] = {4'hF, 2'd0, 4'd0};
        rom_mem[0][0] = {4'd3, 2'd0, 4'd2};
        rom_mem[1][0] = {4'd0, 2'd0, 4'd0};
        rom_mem[1][1] = {4'd1, 2'd0, 4'd1};
        for (int s = 2; s <= 4; s++) begin
            len = $urandom_range(2, 7);
            for (int a = 0; a < len; a++) begin
                r = $urandom_range(0, 3);
                if (r == 0) nt = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'd9;
                else        nt = 4'($urandom_range(1, 7));
                rom_mem[s][a] = {nt, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 3))};
            end
        end

        reset = 1'b1; song_next = 1'b0; song_prev = 1'b0; switches = '0; octave_sel = 2'd0;
        repeat (3) step();
        chk("rst_addr", rom_addr, 0);
        chk("rst_song", rom_song, 0);
        chk("rst_note", note_out, 0);
        chk("rst_octave", octave_out, 0);
        chk("rst_led", led_out, 0);
        chk("rst_hit", hit_cnt, 0);
        chk("rst_miss", miss_cnt, 0);
        chk("rst_pass", pass_done, 0);
        song_next = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("no_edge_after_reset", rom_song, 0);
        song_next = 1'b0;

        // Correct press sounds the note for dur*BEAT_CYCLES cycles, then end marker wraps.
        wait_led(7'b0000100, "t1_led");
        chk("t1_guide_silent", note_out, 0);
        switches = 7'b0000100;
        sounded = 0;
        step();
        while (note_out === 4'd3 && sounded < 40) begin
            sounded++;
            step();
        end
        chk("t1_hold_cycles", sounded, 8);
        switches = '0;
        chk("t1_hit", hit_cnt, 1);
        chk("t1_addr_next", rom_addr, 1);
        step();
        chk("t1_pass_pulse", pass_done, 1);
        step();
        chk("t1_pass_low", pass_done, 0);
        chk("t1_addr_wrap", rom_addr, 0);

        // Right key, wrong octave: stays guiding, one miss per press event.
        wait_led(7'b0000100, "t2_led");
        octave_sel = 2'd1;
        switches = 7'b0000100;
        repeat (4) step();
        chk("t2_silent", note_out, 0);
        chk("t2_led_on", led_out, 7'b0000100);
        chk("t2_miss_one", miss_cnt, 1);
        switches = '0;
        repeat (2) step();
        switches = 7'b0000100;
        repeat (2) step();
        chk("t2_miss_two", miss_cnt, 2);
        chk("t2_hit_kept", hit_cnt, 1);
        switches = '0;
        octave_sel = 2'd0;
        step();

        // Song selection edges.
        song_prev = 1'b1;
        step();
        chk("t3_prev_wrap", rom_song, 5);
        chk("t3_prev_addr", rom_addr, 0);
        chk("t3_prev_hit", hit_cnt, 0);
        chk("t3_prev_miss", miss_cnt, 0);
        song_prev = 1'b0;
        step();
        song_next = 1'b1;
        song_prev = 1'b1;
        step();
        chk("t3_both_ignored", rom_song, 5);
        song_next = 1'b0;
        song_prev = 1'b0;
        step();
        change_song(3'd0);

        // Partial hold: release after 3 cycles, finish with 5 more.
        wait_led(7'b0000100, "t5_led");
        switches = 7'b0000100;
        sounded = 0;
        repeat (3) begin
            step();
            #1;
            if (note_out === 4'd3) sounded++;
        end
        chk("t5_first_part", sounded, 3);
        step();
        switches = '0;
        repeat (3) step();
        chk("t5_released_silent", note_out, 0);
        chk("t5_led_held", led_out, 7'b0000100);
        step();
        switches = 7'b0000100;
        #1;
        sounded = 0;
        while (note_out === 4'd3 && sounded < 40) begin
            sounded++;
            step();
            #1;
        end
        chk("t5_second_part", sounded, 5);
        chk("t5_hit", hit_cnt, 1);
        switches = '0;

        // Song change mid-note: no hit, new song starts at address 0.
        wait_led(7'b0000100, "t6_led");
        switches = 7'b0000100;
        repeat (3) step();
        song_next = 1'b1;
        step();
        chk("t6_song", rom_song, 1);
        chk("t6_addr", rom_addr, 0);
        chk("t6_no_hit", hit_cnt, 0);
        chk("t6_silent", note_out, 0);
        song_next = 1'b0;
        switches = '0;

        // Zero-duration rest lasts one beat and ignores the switches.
        n = 0;
        while (led_out !== 7'b0000001 && n < 40) begin
            step();
            n++;
            if (n == 2) switches = '1;
            if (n == 3) chk("t4_rest_silent", note_out, 0);
            if (n == 4) switches = '0;
        end
        chk("t4_rest_timing", n, 8);
        chk("t4_rest_no_miss", miss_cnt, 0);
        switches = 7'b0000001;
        sounded = 0;
        step();
        while (note_out === 4'd1 && sounded < 40) begin
            sounded++;
            step();
        end
        chk("t4_key1_cycles", sounded, 4);
        chk("t4_hit", hit_cnt, 1);
        switches = '0;

        // Random songs against the note-list model.
        for (int s = 2; s <= 4; s++) begin
            change_song(3'(s));
            play_song(s);
        end
        change_song(3'd5);
        change_song(3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
